// File: rtl/load_store_unit_pkg.sv
// Shared funct3 encodings and FSM state type for the load/store unit.
package load_store_unit_pkg;

    localparam logic [2:0] LF3_LB  = 3'b000;
    localparam logic [2:0] LF3_LH  = 3'b001;
    localparam logic [2:0] LF3_LW  = 3'b010;
    localparam logic [2:0] LF3_LBU = 3'b100;
    localparam logic [2:0] LF3_LHU = 3'b101;

    localparam logic [2:0] SF3_SB  = 3'b000;
    localparam logic [2:0] SF3_SH  = 3'b001;
    localparam logic [2:0] SF3_SW  = 3'b010;

    typedef enum logic {
        LSU_IDLE      = 1'b0,
        LSU_LOAD_RESP = 1'b1
    } lsu_state_e;

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Selects the addressed byte/half lane of a read word and sign- or zero-extends it.
module load_extend
    import load_store_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  loadOp,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (offset)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        result = 32'h0;
        case (loadOp)
            LF3_LB:  result = {{24{byte_sel[7]}}, byte_sel};
            LF3_LH:  result = {{16{half_sel[15]}}, half_sel};
            LF3_LW:  result = rdata;
            LF3_LBU: result = {24'h0, byte_sel};
            LF3_LHU: result = {16'h0, half_sel};
            default: result = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory responder: one-cycle stores, two-cycle loads (one stall cycle)
// against a single-port synchronous word SRAM.
//
// state         | meaning
// LSU_IDLE      | accept a request; outputs follow the request inputs
// LSU_LOAD_RESP | SRAM read data valid; extend it onto loadData
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  memRead,
    input  logic                  memWrite,
    input  logic [2:0]            loadOp,
    input  logic [31:0]           addr,
    input  logic [31:0]           storeData,
    output logic [31:0]           loadData,
    output logic                  stall,
    output logic                  fault,
    output logic                  ramEn,
    output logic                  ramWe,
    output logic [3:0]            ramBe,
    output logic [ADDR_WIDTH-1:0] ramAddr,
    output logic [31:0]           ramWdata,
    input  logic [31:0]           ramRdata
);

    lsu_state_e state_q, state_d;
    logic [1:0] offset_q, offset_d;
    logic [2:0] op_q, op_d;

    logic        is_half, is_word, misaligned;
    logic        load_legal, store_legal, illegal_op;
    logic        fault_det;
    logic [31:0] ext_data;

    // Addresses wrap: bits above the word index are deliberately ignored.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:ADDR_WIDTH+2];

    always_comb begin
        is_half     = (loadOp[1:0] == 2'b01);
        is_word     = (loadOp[1:0] == 2'b10);
        misaligned  = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
        load_legal  = (loadOp == LF3_LB) || (loadOp == LF3_LH) || (loadOp == LF3_LW) ||
                      (loadOp == LF3_LBU) || (loadOp == LF3_LHU);
        store_legal = (loadOp == SF3_SB) || (loadOp == SF3_SH) || (loadOp == SF3_SW);
        illegal_op  = (memRead && !load_legal) || (memWrite && !store_legal);
        fault_det   = (memRead || memWrite) &&
                      (misaligned || illegal_op || (memRead && memWrite));
    end

    load_extend u_load_extend (
        .rdata  (ramRdata),
        .offset (offset_q),
        .loadOp (op_q),
        .result (ext_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= LSU_IDLE;
            offset_q <= 2'b00;
            op_q     <= 3'b000;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            op_q     <= op_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        op_d     = op_q;
        case (state_q)
            LSU_IDLE: begin
                if (memRead && !fault_det) begin
                    state_d  = LSU_LOAD_RESP;
                    offset_d = addr[1:0];
                    op_d     = loadOp;
                end
            end
            LSU_LOAD_RESP: state_d = LSU_IDLE;
            default:       state_d = LSU_IDLE;
        endcase
    end

    always_comb begin
        loadData = 32'h0;
        stall    = 1'b0;
        fault    = 1'b0;
        ramEn    = 1'b0;
        ramWe    = 1'b0;
        ramBe    = 4'b0000;
        ramAddr  = '0;
        ramWdata = 32'h0;
        if (!reset) begin
            case (state_q)
                LSU_IDLE: begin
                    if (fault_det) begin
                        fault = 1'b1;
                    end else if (memWrite) begin
                        ramEn   = 1'b1;
                        ramWe   = 1'b1;
                        ramAddr = addr[ADDR_WIDTH+1:2];
                        case (loadOp)
                            SF3_SB: begin
                                ramBe    = 4'b0001 << addr[1:0];
                                ramWdata = {4{storeData[7:0]}};
                            end
                            SF3_SH: begin
                                ramBe    = addr[1] ? 4'b1100 : 4'b0011;
                                ramWdata = {2{storeData[15:0]}};
                            end
                            default: begin
                                ramBe    = 4'b1111;
                                ramWdata = storeData;
                            end
                        endcase
                    end else if (memRead) begin
                        ramEn   = 1'b1;
                        ramAddr = addr[ADDR_WIDTH+1:2];
                        stall   = 1'b1;
                    end
                end
                LSU_LOAD_RESP: loadData = ext_data;
                default: ;
            endcase
        end
    end

endmodule
